lc3_mem_ctrl: RTL and testbench
===============================

// Module: lc3_mem_ctrl
// PURPOSE
//  Memory/I-O controller downstream of the lc3 core's memory port. Serves core requests (memEN/memWE) from
//  on-chip RAM with configurable wait states and returns memRDY (the core's R signal). Decodes the I/O page
//  into KBSR/KBDR/DSR/DDR/MCR, drives the MCR that gates the core clock, and raises IRQ/INTV/INTP.
// PARAMETERS
//  ADDR_W       14   RAM word-address width (depth 2**ADDR_W); higher address bits ignored (alias)
//  WAIT_STATES  2    extra cycles before memRDY on RAM accesses (0..15)
//  INIT_FILE    ""   $readmemh image for RAM; empty = no init
// PORTS
//  clk           in   1   system clock (ungated; this block must keep running while MCR[15]=0)
//  rst           in   1   synchronous, active-high reset
//  memory_addr   in   16  core address
//  memory_din    in   16  core write data
//  memWE         in   1   1 = write, 0 = read (valid while memEN)
//  memEN         in   1   access request
//  memory_dout   out  16  read data, valid when memRDY=1 and held until next completion
//  memRDY        out  1   1-cycle completion pulse
//  MCR           out  16  machine control register to core; bit15 = clock enable
//  kbd_data      in   8   keyboard character
//  kbd_valid     in   1   keyboard character offered
//  kbd_ready     out  1   = !KBSR[15]
//  disp_data     out  8   display character
//  disp_valid    out  1   display character pending
//  disp_ready    in   1   display sink accepts
//  IRQ           out  1   interrupt request
//  INTV          out  8   interrupt vector
//  INTP          out  3   interrupt priority
// BEHAVIOUR
//  Reset: FSM=IDLE, memRDY=0, memory_dout=0, MCR=16'h8000, KBSR=0, KBDR=0, DSR=16'h8000, disp_valid=0,
//    disp_data=0, IRQ=0, INTV=0, INTP=0. RAM contents untouched by reset (also mid-access: access dropped).
//  FSM IDLE->WAIT->DONE->IDLE. In IDLE with memEN=1: latch addr/din/we, load wait counter.
//    RAM access: WAIT_STATES cycles in WAIT (0 = skip WAIT), then DONE. I/O access (addr>=16'hFE00): straight to DONE.
//    DONE: memRDY=1 for exactly one cycle; write committed, read data on memory_dout. Next cycle IDLE
//    samples memEN again, so back-to-back requests are new accesses (min 2 cycles each). memEN/addr changes
//    during WAIT are ignored (latched values used).
//  I/O map: FE00 KBSR, FE02 KBDR, FE04 DSR, FE06 DDR, FFFE MCR; other FExx-FFFF reads return 0, writes ignored.
//  KBSR[15] ready (read-only), KBSR[14] IE (rw). kbd_valid&kbd_ready: KBDR<={8'h0,kbd_data}, KBSR[15]<=1.
//    Read of KBDR completing (DONE) clears KBSR[15].
//  DSR[15] ready (read-only), DSR[14] IE (rw). Write DDR while DSR[15]=1: disp_data<=din[7:0],
//    disp_valid<=1, DSR[15]<=0. Write DDR while DSR[15]=0: dropped. disp_valid&disp_ready: disp_valid<=0,
//    DSR[15]<=1. Reads of DDR return {8'h0,disp_data}.
//  MCR fully writable; write clearing bit15 halts core; only rst restores 16'h8000.
//  IRQ registered: kbd_int=KBSR[15]&KBSR[14], dsp_int=DSR[15]&DSR[14]; IRQ=kbd_int|dsp_int;
//    kbd_int wins: INTV=8'h80 else 8'h81 if dsp_int; INTP=3'd4 when IRQ else 0.
// STRUCTURE
//  Package lc3_mem_pkg: I/O address localparams, FSM state enum, vector/priority constants.
//  Sub-module lc3_sram: single-port synchronous RAM (ADDR_W, INIT_FILE); controller holds FSM and I/O regs.
// TESTING
//  RAM write 16'h1234->x3000 then read x3000, WAIT_STATES=2 -> memRDY 4 cycles after memEN, dout=16'h1234.
//  kbd_valid with 8'h41 -> KBSR=16'h8000, kbd_ready=0; read FE02 -> dout=16'h0041, KBSR[15]=0 after.
//  Write FE00=16'h4000 then key arrives -> IRQ=1, INTV=8'h80, INTP=3'd4; read KBDR -> IRQ drops.
//  Write FE06=16'h0058, disp_ready=0 5 cycles -> disp_valid=1, DSR=0; second write dropped; ready -> DSR=8000.
//  Write FFFE=16'h0000 -> MCR=0; read xFE08 -> 0; rst asserted in WAIT -> memRDY never pulses, MCR=8000.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared constants for the lc3 memory/I-O controller:
// I/O page map, FSM encodings and interrupt vectors.
package lc3_mem_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic [15:0] IO_BASE   = 16'hFE00;
    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

    localparam logic [15:0] MCR_RESET = 16'h8000;

    localparam logic [7:0] VEC_KBD = 8'h80;
    localparam logic [7:0] VEC_DSP = 8'h81;
    localparam logic [2:0] PRI_IO  = 3'd4;

    function automatic logic isIoAddr(input logic [15:0] a);
        return a >= IO_BASE;
    endfunction

endpackage

// File: rtl/lc3_sram.sv
// Single-port synchronous RAM for lc3.
// Registered read of the presented address.
module lc3_sram #(
  parameter int ADDR_W    = 14,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// Memory/I-O controller behind the lc3 core memory port:
// RAM with wait states, keyboard/display/MCR registers, IRQ.
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int WAIT_STATES = 2,
    parameter     INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] memory_addr,
    input  logic [15:0] memory_din,
    input  logic        memWE,
    input  logic        memEN,
    output logic [15:0] memory_dout,
    output logic        memRDY,
    output logic [15:0] MCR,
    input  logic [7:0]  kbd_data,
    input  logic        kbd_valid,
    output logic        kbd_ready,
    output logic [7:0]  disp_data,
    output logic        disp_valid,
    input  logic        disp_ready,
    output logic        IRQ,
    output logic [7:0]  INTV,
    output logic [2:0]  INTP
);

    localparam bit NO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] WS_LOAD =
        NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t      state;
    logic [3:0]  waitCnt;
    logic [15:0] addrQ;
    logic [15:0] dinQ;
    logic        weQ;
    logic [15:0] doutQ;
    logic        rdyQ;

    logic [15:0] mcrQ;
    logic        kbsrRdy;
    logic        kbsrIe;
    logic [7:0]  kbdrQ;
    logic        dsrRdy;
    logic        dsrIe;
    logic [7:0]  dispDataQ;
    logic        dispValidQ;
    logic        irqQ;
    logic [7:0]  intvQ;
    logic [2:0]  intpQ;

    logic        done;
    logic        isIo;
    logic        ioWr;
    logic        ioRd;
    logic        ramWe;
    logic [15:0] ramAddr;
    logic [15:0] ramRdata;
    logic [15:0] ioRdata;
    logic        kbdInt;
    logic        dspInt;

    assign done   = (state == ST_DONE);
    assign isIo   = isIoAddr(addrQ);
    assign ioWr   = done && weQ && isIo;
    assign ioRd   = done && !weQ && isIo;
    assign ramWe  = done && weQ && !isIo && !rst;
    assign kbdInt = kbsrRdy && kbsrIe;
    assign dspInt = dsrRdy && dsrIe;

    // IDLE looks at the live bus so read data is ready by DONE.
    assign ramAddr = (state == ST_IDLE) ? memory_addr : addrQ;

    lc3_sram #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) uSram (
        .clk   (clk),
        .we    (ramWe),
        .addr  (ramAddr[ADDR_W-1:0]),
        .wdata (dinQ),
        .rdata (ramRdata)
    );

    // Read mux for the I/O page; unmapped addresses return zero.
    always_comb begin
        ioRdata = 16'h0000;
        case (addrQ)
            KBSR_ADDR: ioRdata = {kbsrRdy, kbsrIe, 14'h0};
            KBDR_ADDR: ioRdata = {8'h00, kbdrQ};
            DSR_ADDR:  ioRdata = {dsrRdy, dsrIe, 14'h0};
            DDR_ADDR:  ioRdata = {8'h00, dispDataQ};
            MCR_ADDR:  ioRdata = mcrQ;
            default:   ioRdata = 16'h0000;
        endcase
    end

    // Access sequencer: latch request, count wait states, complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            waitCnt <= 4'd0;
            addrQ   <= 16'h0000;
            dinQ    <= 16'h0000;
            weQ     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (memEN) begin
                        addrQ   <= memory_addr;
                        dinQ    <= memory_din;
                        weQ     <= memWE;
                        waitCnt <= WS_LOAD;
                        if (isIoAddr(memory_addr) || NO_WAIT) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (waitCnt == 4'd0) begin
                        state <= ST_DONE;
                    end else begin
                        waitCnt <= waitCnt - 4'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Completion pulse and held read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdyQ  <= 1'b0;
            doutQ <= 16'h0000;
        end else begin
            rdyQ <= done;
            if (done && !weQ) begin
                doutQ <= isIo ? ioRdata : ramRdata;
            end
        end
    end

    // Machine control register; only reset brings the clock back.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcrQ <= MCR_RESET;
        end else if (ioWr && addrQ == MCR_ADDR) begin
            mcrQ <= dinQ;
        end
    end

    // Keyboard: accept a key when empty, reading KBDR empties it.
    always_ff @(posedge clk) begin
        if (rst) begin
            kbsrRdy <= 1'b0;
            kbsrIe  <= 1'b0;
            kbdrQ   <= 8'h00;
        end else begin
            if (kbd_valid && !kbsrRdy) begin
                kbdrQ   <= kbd_data;
                kbsrRdy <= 1'b1;
            end else if (ioRd && addrQ == KBDR_ADDR) begin
                kbsrRdy <= 1'b0;
            end
            if (ioWr && addrQ == KBSR_ADDR) begin
                kbsrIe <= dinQ[14];
            end
        end
    end

    // Display: one character in flight, sink handshake frees it.
    always_ff @(posedge clk) begin
        if (rst) begin
            dsrRdy     <= 1'b1;
            dsrIe      <= 1'b0;
            dispDataQ  <= 8'h00;
            dispValidQ <= 1'b0;
        end else begin
            if (dispValidQ && disp_ready) begin
                dispValidQ <= 1'b0;
                dsrRdy     <= 1'b1;
            end else if (ioWr && addrQ == DDR_ADDR && dsrRdy) begin
                dispDataQ  <= dinQ[7:0];
                dispValidQ <= 1'b1;
                dsrRdy     <= 1'b0;
            end
            if (ioWr && addrQ == DSR_ADDR) begin
                dsrIe <= dinQ[14];
            end
        end
    end

    // Registered interrupt request; keyboard outranks display.
    always_ff @(posedge clk) begin
        if (rst) begin
            irqQ  <= 1'b0;
            intvQ <= 8'h00;
            intpQ <= 3'd0;
        end else begin
            irqQ  <= kbdInt || dspInt;
            intpQ <= (kbdInt || dspInt) ? PRI_IO : 3'd0;
            if (kbdInt) begin
                intvQ <= VEC_KBD;
            end else if (dspInt) begin
                intvQ <= VEC_DSP;
            end else begin
                intvQ <= 8'h00;
            end
        end
    end

    assign memory_dout = doutQ;
    assign memRDY      = rdyQ;
    assign MCR         = mcrQ;
    assign kbd_ready   = !kbsrRdy;
    assign disp_data   = dispDataQ;
    assign disp_valid  = dispValidQ;
    assign IRQ         = irqQ;
    assign INTV        = intvQ;
    assign INTP        = intpQ;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl (WAIT_STATES=2).
// Expected read data is queued at issue and checked at memRDY.
module tb_lc3_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] memory_addr = 16'h0000;
    logic [15:0] memory_din = 16'h0000;
    logic        memWE = 1'b0;
    logic        memEN = 1'b0;
    logic [15:0] memory_dout;
    logic        memRDY;
    logic [15:0] MCR;
    logic [7:0]  kbd_data = 8'h00;
    logic        kbd_valid = 1'b0;
    logic        kbd_ready;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        disp_ready = 1'b0;
    logic        IRQ;
    logic [7:0]  INTV;
    logic [2:0]  INTP;

    int nChecks = 0;
    int nFails = 0;
    logic [15:0] sb [$];

    lc3_mem_ctrl #(
        .ADDR_W      (14),
        .WAIT_STATES (2),
        .INIT_FILE   ("")
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .memory_addr (memory_addr),
        .memory_din  (memory_din),
        .memWE       (memWE),
        .memEN       (memEN),
        .memory_dout (memory_dout),
        .memRDY      (memRDY),
        .MCR         (MCR),
        .kbd_data    (kbd_data),
        .kbd_valid   (kbd_valid),
        .kbd_ready   (kbd_ready),
        .disp_data   (disp_data),
        .disp_valid  (disp_valid),
        .disp_ready  (disp_ready),
        .IRQ         (IRQ),
        .INTV        (INTV),
        .INTP        (INTP)
    );

    always #5 clk = ~clk;

    // One core access; latency counts edges from the one sampling memEN.
    task automatic access(input logic [15:0] a, input logic [15:0] d,
                          input logic w, input int expLat,
                          input string name);
        int lat;
        logic [15:0] exp;
        @(negedge clk);
        memory_addr = a;
        memory_din = d;
        memWE = w;
        memEN = 1'b1;
        @(posedge clk);
        #1;
        lat = 1;
        memEN = 1'b0;
        memory_addr = 16'h0000;
        memWE = ~w;
        while (!memRDY && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        nChecks++;
        if (!memRDY) begin
            nFails++;
            $display("FAIL %s timeout: no memRDY within %0d cycles", name, lat);
        end else begin
            if (lat !== expLat) begin
                nFails++;
                $display("FAIL %s latency: got %0d want %0d", name, lat, expLat);
            end
            if (!w) begin
                exp = sb.pop_front();
                nChecks++;
                if (memory_dout !== exp) begin
                    nFails++;
                    $display("FAIL %s data: got %h want %h", name, memory_dout, exp);
                end
            end
        end
        memWE = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp,
                      input int lat, input string name);
        sb.push_back(exp);
        access(a, 16'h0000, 1'b0, lat, name);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d,
                      input int lat, input string name);
        access(a, d, 1'b1, lat, name);
    endtask

    task automatic keyPress(input logic [7:0] k);
        @(negedge clk);
        kbd_data = k;
        kbd_valid = 1'b1;
        @(posedge clk);
        #1;
        kbd_valid = 1'b0;
    endtask

    task automatic checkIrq(input logic i, input logic [7:0] v,
                            input logic [2:0] p, input string name);
        nChecks++;
        if (IRQ !== i || INTV !== v || INTP !== p) begin
            nFails++;
            $display("FAIL %s irq: got %b/%h/%0d want %b/%h/%0d",
                     name, IRQ, INTV, INTP, i, v, p);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        nChecks++;
        if (memRDY !== 1'b0 || memory_dout !== 16'h0000) begin
            nFails++;
            $display("FAIL reset bus: rdy %b dout %h want 0 0000", memRDY, memory_dout);
        end
        nChecks++;
        if (MCR !== 16'h8000) begin
            nFails++;
            $display("FAIL reset MCR: got %h want 8000", MCR);
        end
        nChecks++;
        if (kbd_ready !== 1'b1 || disp_valid !== 1'b0 || disp_data !== 8'h00) begin
            nFails++;
            $display("FAIL reset io: kr %b dv %b dd %h want 1 0 00",
                     kbd_ready, disp_valid, disp_data);
        end
        checkIrq(1'b0, 8'h00, 3'd0, "reset");
        rd(16'hFE04, 16'h8000, 2, "reset DSR");
        rd(16'hFE00, 16'h0000, 2, "reset KBSR");
    endtask

    task automatic test_ram();
        wr(16'h3000, 16'h1234, 4, "ram wr");
        rd(16'h3000, 16'h1234, 4, "ram rd");
        wr(16'h3001, 16'h5555, 4, "ram wr2");
        rd(16'h7000, 16'h1234, 4, "ram alias");
        rd(16'h3001, 16'h5555, 4, "ram rd2");
    endtask

    task automatic test_kbd();
        keyPress(8'h41);
        nChecks++;
        if (kbd_ready !== 1'b0) begin
            nFails++;
            $display("FAIL kbd ready: got %b want 0", kbd_ready);
        end
        rd(16'hFE00, 16'h8000, 2, "kbd KBSR full");
        rd(16'hFE02, 16'h0041, 2, "kbd KBDR");
        rd(16'hFE00, 16'h0000, 2, "kbd KBSR empty");
        nChecks++;
        if (kbd_ready !== 1'b1) begin
            nFails++;
            $display("FAIL kbd ready after read: got %b want 1", kbd_ready);
        end
    endtask

    task automatic test_kbd_irq();
        wr(16'hFE00, 16'h4000, 2, "kbd ie");
        checkIrq(1'b0, 8'h00, 3'd0, "kbd ie only");
        keyPress(8'h42);
        @(posedge clk);
        #1;
        checkIrq(1'b1, 8'h80, 3'd4, "kbd irq");
        rd(16'hFE00, 16'hC000, 2, "kbd KBSR ie");
        rd(16'hFE02, 16'h0042, 2, "kbd KBDR irq");
        @(posedge clk);
        #1;
        checkIrq(1'b0, 8'h00, 3'd0, "kbd irq drop");
        wr(16'hFE00, 16'h0000, 2, "kbd ie off");
    endtask

    task automatic test_display();
        wr(16'hFE06, 16'h0058, 2, "ddr wr");
        repeat (5) @(posedge clk);
        #1;
        nChecks++;
        if (disp_valid !== 1'b1 || disp_data !== 8'h58) begin
            nFails++;
            $display("FAIL disp pending: dv %b dd %h want 1 58", disp_valid, disp_data);
        end
        rd(16'hFE04, 16'h0000, 2, "dsr busy");
        wr(16'hFE06, 16'h0059, 2, "ddr wr dropped");
        rd(16'hFE06, 16'h0058, 2, "ddr rd");
        @(negedge clk);
        disp_ready = 1'b1;
        @(posedge clk);
        #1;
        disp_ready = 1'b0;
        nChecks++;
        if (disp_valid !== 1'b0) begin
            nFails++;
            $display("FAIL disp accept: dv %b want 0", disp_valid);
        end
        rd(16'hFE04, 16'h8000, 2, "dsr ready");
    endtask

    task automatic test_dsp_irq();
        wr(16'hFE04, 16'h4000, 2, "dsr ie");
        @(posedge clk);
        #1;
        checkIrq(1'b1, 8'h81, 3'd4, "dsp irq");
        wr(16'hFE00, 16'h4000, 2, "both ie");
        keyPress(8'h43);
        @(posedge clk);
        #1;
        checkIrq(1'b1, 8'h80, 3'd4, "kbd wins");
        rd(16'hFE02, 16'h0043, 2, "kbd KBDR prio");
        @(posedge clk);
        #1;
        checkIrq(1'b1, 8'h81, 3'd4, "dsp after kbd");
        wr(16'hFE04, 16'h0000, 2, "dsr ie off");
        wr(16'hFE00, 16'h0000, 2, "kbd ie off2");
        @(posedge clk);
        #1;
        checkIrq(1'b0, 8'h00, 3'd0, "irq clear");
    endtask

    task automatic test_mcr_unmapped();
        rd(16'hFE08, 16'h0000, 2, "unmapped rd");
        wr(16'hFE08, 16'hFFFF, 2, "unmapped wr");
        rd(16'hFE08, 16'h0000, 2, "unmapped rd2");
        rd(16'hFFFE, 16'h8000, 2, "mcr rd");
        wr(16'hFFFE, 16'h0000, 2, "mcr wr");
        nChecks++;
        if (MCR !== 16'h0000) begin
            nFails++;
            $display("FAIL mcr halt: got %h want 0000", MCR);
        end
        rd(16'hFFFE, 16'h0000, 2, "mcr rd0");
        rd(16'h3000, 16'h1234, 4, "ram while halted");
    endtask

    task automatic test_reset_in_wait();
        bit seen;
        @(negedge clk);
        memory_addr = 16'h3001;
        memory_din = 16'hBEEF;
        memWE = 1'b1;
        memEN = 1'b1;
        @(posedge clk);
        #1;
        memEN = 1'b0;
        memWE = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (memRDY) seen = 1'b1;
        end
        nChecks++;
        if (seen !== 1'b0) begin
            nFails++;
            $display("FAIL rst in wait: memRDY pulsed got 1 want 0");
        end
        nChecks++;
        if (MCR !== 16'h8000) begin
            nFails++;
            $display("FAIL rst MCR: got %h want 8000", MCR);
        end
        rd(16'h3001, 16'h5555, 4, "rst dropped write");
    endtask

    task automatic test_back_to_back();
        int hits;
        int at0;
        int at1;
        logic [15:0] exp;
        hits = 0;
        at0 = 0;
        at1 = 0;
        sb.push_back(16'h1234);
        sb.push_back(16'h5555);
        @(negedge clk);
        memory_addr = 16'h3000;
        memWE = 1'b0;
        memEN = 1'b1;
        for (int c = 1; c <= 20 && hits < 2; c++) begin
            @(posedge clk);
            #1;
            if (memRDY) begin
                nChecks++;
                if (sb.size() == 0) begin
                    nFails++;
                    $display("FAIL b2b extra memRDY at cycle %0d want none", c);
                end else begin
                    exp = sb.pop_front();
                    if (memory_dout !== exp) begin
                        nFails++;
                        $display("FAIL b2b data: got %h want %h", memory_dout, exp);
                    end
                end
                if (hits == 0) begin
                    at0 = c;
                    memory_addr = 16'h3001;
                end else begin
                    at1 = c;
                    memEN = 1'b0;
                end
                hits++;
            end
        end
        memEN = 1'b0;
        sb.delete();
        nChecks++;
        if (at0 !== 4 || at1 !== 8) begin
            nFails++;
            $display("FAIL b2b timing: got %0d,%0d want 4,8", at0, at1);
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_kbd();
        test_kbd_irq();
        test_display();
        test_dsp_irq();
        test_mcr_unmapped();
        test_reset_in_wait();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule
